// File: rtl/bht_resolve_queue.sv
// In-flight branch tracker between fetch and execute. Holds predicted branches in a
// circular FIFO, trains the BHT on every in-order resolution and raises a redirect
// (with a full flush of younger wrong-path entries) on a target mispredict.
module bht_resolve_queue #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned depth      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENQ_VALID,
    output logic                    ENQ_READY,
    input  logic [addr_width-1:0]   ENQ_PC,
    input  logic [addr_width-1:0]   ENQ_PRED_TGT,
    input  logic                    RES_VALID,
    output logic                    RES_READY,
    input  logic                    RES_TAKEN,
    input  logic [addr_width-1:0]   RES_TGT,
    output logic                    UPD_WE,
    output logic [addr_width-1:0]   UPD_PC,
    output logic                    UPD_TAKE,
    output logic                    REDIR_VALID,
    output logic [addr_width-1:0]   REDIR_PC,
    output logic [$clog2(depth):0]  COUNT,
    output logic [15:0]             MISP_CNT
);

    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);

    typedef enum logic [0:0] {StRun, StRedirect} state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [15:0]           misp_cnt_q, misp_cnt_d;
    logic                  upd_we_q, upd_we_d;
    logic [addr_width-1:0] upd_pc_q, upd_pc_d;
    logic                  upd_take_q, upd_take_d;
    logic                  redir_valid_q, redir_valid_d;
    logic [addr_width-1:0] redir_pc_q, redir_pc_d;

    logic [addr_width-1:0] pc_mem_q  [depth];
    logic [addr_width-1:0] tgt_mem_q [depth];

    logic enq_fire;
    logic res_fire;
    logic mispredict;
    logic res_ok;
    logic enq_accept;

    // Handshakes: readiness depends only on reset, state and occupancy.
    always_comb begin
        ENQ_READY  = !RST && (state_q == StRun) && (count_q < DepthCnt);
        RES_READY  = !RST && (state_q == StRun) && (count_q != '0);
        enq_fire   = ENQ_VALID && ENQ_READY;
        res_fire   = RES_VALID && RES_READY;
        mispredict = res_fire && (RES_TGT != tgt_mem_q[head_q]);
        res_ok     = res_fire && !mispredict;
        // A same-cycle enqueue during a mispredict is on the wrong path and is dropped.
        enq_accept = enq_fire && !mispredict;
    end

    // Next-state: pointers, occupancy, training/redirect pulses and FSM.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        misp_cnt_d    = misp_cnt_q;
        upd_we_d      = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_take_d    = upd_take_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;

        unique case (state_q)
            StRun:      state_d = StRun;
            StRedirect: state_d = StRun;
            default:    state_d = StRun;
        endcase

        if (res_fire) begin
            upd_we_d   = 1'b1;
            upd_pc_d   = pc_mem_q[head_q];
            upd_take_d = RES_TAKEN;
        end

        if (enq_accept) begin
            tail_d = tail_q + 1'b1;
        end

        if (res_ok) begin
            head_d = head_q + 1'b1;
        end

        unique case ({enq_accept, res_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mispredict) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            redir_valid_d = 1'b1;
            redir_pc_d    = RES_TGT;
            misp_cnt_d    = misp_cnt_q + 16'd1;
            state_d       = StRedirect;
        end
    end

    // Control and output registers; reset overrides every event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StRun;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            misp_cnt_q    <= '0;
            upd_we_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_take_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            misp_cnt_q    <= misp_cnt_d;
            upd_we_q      <= upd_we_d;
            upd_pc_q      <= upd_pc_d;
            upd_take_q    <= upd_take_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge CLK) begin
        if (enq_accept) begin
            pc_mem_q[tail_q]  <= ENQ_PC;
            tgt_mem_q[tail_q] <= ENQ_PRED_TGT;
        end
    end

    assign UPD_WE      = upd_we_q;
    assign UPD_PC      = upd_pc_q;
    assign UPD_TAKE    = upd_take_q;
    assign REDIR_VALID = redir_valid_q;
    assign REDIR_PC    = redir_pc_q;
    assign COUNT       = count_q;
    assign MISP_CNT    = misp_cnt_q;

endmodule

// File: tb/tb_bht_resolve_queue.sv
// Directed bench for bht_resolve_queue (depth 4, 32-bit PCs).
module tb_bht_resolve_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_pred_tgt;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [31:0] res_tgt;
    logic        upd_we;
    logic [31:0] upd_pc;
    logic        upd_take;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [2:0]  count;
    logic [15:0] misp_cnt;

    int checks = 0;
    int errors = 0;

    bht_resolve_queue #(
        .addr_width (32),
        .depth      (4)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .ENQ_VALID    (enq_valid),
        .ENQ_READY    (enq_ready),
        .ENQ_PC       (enq_pc),
        .ENQ_PRED_TGT (enq_pred_tgt),
        .RES_VALID    (res_valid),
        .RES_READY    (res_ready),
        .RES_TAKEN    (res_taken),
        .RES_TGT      (res_tgt),
        .UPD_WE       (upd_we),
        .UPD_PC       (upd_pc),
        .UPD_TAKE     (upd_take),
        .REDIR_VALID  (redir_valid),
        .REDIR_PC     (redir_pc),
        .COUNT        (count),
        .MISP_CNT     (misp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        enq_valid    = 1'b0;
        enq_pc       = '0;
        enq_pred_tgt = '0;
        res_valid    = 1'b0;
        res_taken    = 1'b0;
        res_tgt      = '0;

        // Reset state
        step();
        step();
        check("rst_enq_ready", 32'(enq_ready), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_upd_we", 32'(upd_we), 32'd0);
        check("rst_upd_pc", upd_pc, 32'd0);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_redir_pc", redir_pc, 32'd0);
        check("rst_misp_cnt", 32'(misp_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("run_enq_ready", 32'(enq_ready), 32'd1);
        check("run_res_ready_empty", 32'(res_ready), 32'd0);

        // Resolve while empty is not accepted
        res_valid = 1'b1;
        res_tgt   = 32'h999;
        #1;
        check("empty_res_ready", 32'(res_ready), 32'd0);
        step();
        res_valid = 1'b0;
        check("empty_upd_we", 32'(upd_we), 32'd0);
        check("empty_misp", 32'(misp_cnt), 32'd0);

        // Single correct prediction
        enq_valid = 1'b1; enq_pc = 32'h100; enq_pred_tgt = 32'h104;
        step();
        enq_valid = 1'b0;
        check("t1_count1", 32'(count), 32'd1);
        check("t1_res_ready", 32'(res_ready), 32'd1);
        res_valid = 1'b1; res_tgt = 32'h104; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        check("t1_upd_we", 32'(upd_we), 32'd1);
        check("t1_upd_pc", upd_pc, 32'h100);
        check("t1_upd_take", 32'(upd_take), 32'd0);
        check("t1_redir_valid", 32'(redir_valid), 32'd0);
        check("t1_count0", 32'(count), 32'd0);
        step();
        check("t1_upd_we_pulse", 32'(upd_we), 32'd0);
        check("t1_upd_pc_hold", upd_pc, 32'h100);

        // Fill to depth
        for (int i = 1; i <= 4; i++) begin
            enq_valid = 1'b1; enq_pc = 32'(i * 16); enq_pred_tgt = 32'(i * 16 + 4);
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_enq_ready", 32'(enq_ready), 32'd0);
        enq_pc = 32'h50; enq_pred_tgt = 32'h54;
        step();
        check("full_no_accept", 32'(count), 32'd4);
        // Resolve with the 5th enqueue still held: only the resolve fires
        res_valid = 1'b1; res_tgt = 32'h14; res_taken = 1'b1;
        step();
        enq_valid = 1'b0;
        check("full_res_upd_pc", upd_pc, 32'h10);
        check("full_res_take", 32'(upd_take), 32'd1);
        check("full_res_count", 32'(count), 32'd3);
        check("full_reopen", 32'(enq_ready), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            res_tgt = 32'(i * 16 + 4);
            step();
            check("drain_upd_we", 32'(upd_we), 32'd1);
            check("drain_upd_pc", upd_pc, 32'(i * 16));
        end
        res_valid = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_misp", 32'(misp_cnt), 32'd0);

        // Mispredict with a same-cycle wrong-path enqueue
        enq_valid = 1'b1; enq_pc = 32'h200; enq_pred_tgt = 32'h204;
        step();
        enq_pc = 32'h300; enq_pred_tgt = 32'h304;
        step();
        enq_pc = 32'h400; enq_pred_tgt = 32'h404;
        res_valid = 1'b1; res_tgt = 32'h240; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        check("mp_upd_we", 32'(upd_we), 32'd1);
        check("mp_upd_pc", upd_pc, 32'h200);
        check("mp_upd_take", 32'(upd_take), 32'd1);
        check("mp_redir_valid", 32'(redir_valid), 32'd1);
        check("mp_redir_pc", redir_pc, 32'h240);
        check("mp_misp_cnt", 32'(misp_cnt), 32'd1);
        check("mp_count", 32'(count), 32'd0);
        check("mp_enq_ready", 32'(enq_ready), 32'd0);
        check("mp_res_ready", 32'(res_ready), 32'd0);
        step();
        enq_valid = 1'b0;
        check("mp_reopen", 32'(enq_ready), 32'd1);
        check("mp_redir_pulse", 32'(redir_valid), 32'd0);
        check("mp_upd_pulse", 32'(upd_we), 32'd0);
        check("mp_redir_pc_hold", redir_pc, 32'h240);
        check("mp_not_stored", 32'(count), 32'd0);

        // Steady two-entry occupancy across pointer wrap
        for (int k = 0; k < 2; k++) begin
            enq_valid = 1'b1; enq_pc = 32'h500 + 32'(k * 16); enq_pred_tgt = 32'h504 + 32'(k * 16);
            step();
        end
        check("wrap_prefill", 32'(count), 32'd2);
        for (int i = 0; i < 12; i++) begin
            enq_valid = 1'b1;
            enq_pc = 32'h500 + 32'((i + 2) * 16); enq_pred_tgt = 32'h504 + 32'((i + 2) * 16);
            res_valid = 1'b1; res_taken = i[0];
            res_tgt = 32'h504 + 32'(i * 16);
            step();
            check("wrap_count", 32'(count), 32'd2);
            check("wrap_upd_we", 32'(upd_we), 32'd1);
            check("wrap_upd_pc", upd_pc, 32'h500 + 32'(i * 16));
            check("wrap_redir", 32'(redir_valid), 32'd0);
        end
        res_valid = 1'b0;
        // Third entry, then a mispredict followed by reset in the pulse cycle
        enq_pc = 32'h800; enq_pred_tgt = 32'h804;
        step();
        enq_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        res_valid = 1'b1; res_tgt = 32'h123; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        check("pre_rst_redir", 32'(redir_valid), 32'd1);
        check("pre_rst_misp", 32'(misp_cnt), 32'd2);
        rst = 1'b1;
        enq_valid = 1'b1;
        step();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_upd_we", 32'(upd_we), 32'd0);
        check("post_rst_redir", 32'(redir_valid), 32'd0);
        check("post_rst_misp", 32'(misp_cnt), 32'd0);
        check("post_rst_redir_pc", redir_pc, 32'd0);
        check("post_rst_enq_ready", 32'(enq_ready), 32'd0);

        // Reset with entries queued and a resolve presented
        rst = 1'b0;
        enq_pc = 32'h900; enq_pred_tgt = 32'h904;
        for (int i = 0; i < 3; i++) step();
        enq_valid = 1'b0;
        check("q3_count", 32'(count), 32'd3);
        rst = 1'b1;
        res_valid = 1'b1; res_tgt = 32'h904;
        step();
        res_valid = 1'b0;
        check("q3_rst_count", 32'(count), 32'd0);
        check("q3_rst_upd_we", 32'(upd_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
